// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read handshake (req/addr out, ack/rdata back).
interface fetch_unit_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle instruction fetch sequencer.
// Samples the PC, reads one word from instruction memory, loads the IR and
// hands PC+4 back to the PC with a one-cycle write strobe. Misaligned and
// out-of-range PCs fault without touching memory.
// Optional memory watchdog: define FETCH_TIMEOUT_EN to fault (cause 11) when
// imem_ack does not arrive within TIMEOUT_CYCLES request cycles.
module fetch_unit #(
  parameter logic [31:0] IMEM_ADDRESS_OFFSET = 32'h0040_0000,
  parameter int unsigned IMEM_DEPTH_WORDS    = 2048,
  parameter int unsigned TIMEOUT_CYCLES      = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_start,
  input  logic               flush,
  input  logic [31:0]        pc_in,
  output logic               pc_read,
  output logic               pc_write,
  output logic [31:0]        pc_next,
  fetch_unit_if.master       imem,
  output logic [31:0]        ir_out,
  output logic [31:0]        pc_plus4_out,
  output logic               busy,
  output logic               fetch_done,
  output logic               fetch_fault,
  output logic [1:0]         fault_cause
);

  localparam int unsigned XLEN        = 32;
  localparam logic [XLEN-1:0] RANGE_BYTES = XLEN'(IMEM_DEPTH_WORDS * 4);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] rel_addr;
  logic            start_ok;
  logic            capture;
  logic            timeout_hit;
  logic [1:0]      cause_new;

  logic            pc_read_d;
  logic            busy_d;
  logic            req_d;
  logic            done_d;
  logic [XLEN-1:0] addr_d;
  logic [XLEN-1:0] ir_d;
  logic [XLEN-1:0] pc4_d;
  logic            fault_d;
  logic [1:0]      cause_d;

  assign rel_addr = pc_in - IMEM_ADDRESS_OFFSET;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;

  logic [TW-1:0] wait_q;

  // Count request cycles without ack; restarts whenever REQ is (re)entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else if (state_q == S_REQ && !imem.imem_ack) begin
      wait_q <= wait_q + TW'(1);
    end else begin
      wait_q <= '0;
    end
  end

  // Terminal count reached in this cycle with no ack (ack still wins).
  assign timeout_hit = (state_q == S_REQ) && !imem.imem_ack &&
                       (wait_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout_hit           = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush always returns to IDLE and beats start/ack.
  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    cause_new = CAUSE_NONE;
    case (state_q)
      S_IDLE: begin
        if (fetch_start && !flush) begin
          start_ok = 1'b1;
          if (pc_in[1:0] != 2'b00) begin
            state_d   = S_FAULT;
            cause_new = CAUSE_MISALIGN;
          end else if (rel_addr >= RANGE_BYTES) begin
            state_d   = S_FAULT;
            cause_new = CAUSE_RANGE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (imem.imem_ack) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d   = S_FAULT;
          cause_new = CAUSE_TIMEOUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs, decoded from the next state.
  always_comb begin
    pc_read_d = (state_d == S_IDLE);
    busy_d    = (state_d != S_IDLE);
    req_d     = (state_d == S_REQ);
    done_d    = (state_d == S_DONE);
    capture   = (state_q == S_REQ) && !flush && imem.imem_ack;
    addr_d    = start_ok ? pc_in : addr_q;
    ir_d      = capture ? imem.imem_rdata : ir_out;
    pc4_d     = capture ? (addr_q + XLEN'(4)) : pc_plus4_out;
    fault_d   = fetch_fault;
    cause_d   = fault_cause;
    if (start_ok) begin
      fault_d = 1'b0;
      cause_d = CAUSE_NONE;
    end
    if (state_d == S_FAULT) begin
      fault_d = 1'b1;
      cause_d = cause_new;
    end
  end

  // Output registers; reset drops the memory request asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_read       <= 1'b1;
      busy          <= 1'b0;
      imem.imem_req <= 1'b0;
      addr_q        <= '0;
      ir_out        <= '0;
      pc_plus4_out  <= '0;
      pc_write      <= 1'b0;
      fetch_done    <= 1'b0;
      fetch_fault   <= 1'b0;
      fault_cause   <= CAUSE_NONE;
    end else begin
      pc_read       <= pc_read_d;
      busy          <= busy_d;
      imem.imem_req <= req_d;
      addr_q        <= addr_d;
      ir_out        <= ir_d;
      pc_plus4_out  <= pc4_d;
      pc_write      <= done_d;
      fetch_done    <= done_d;
      fetch_fault   <= fault_d;
      fault_cause   <= cause_d;
    end
  end

  assign imem.imem_addr = addr_q;
  assign pc_next        = pc_plus4_out;

endmodule
